// File: rtl/step_controller.sv
// rtl/step_controller.sv - button-driven single-step and free-run CPU step enable generator
//
// Purpose:
//   Turns each clean button press into exactly one single-cycle step enable,
//   or produces a periodic step enable every RUN_DIV cycles in free-run mode.
//   Stepping is frozen while the core reports halt.
//
// Ports:
//   clk_in      system clock
//   rst_n       asynchronous active-low reset
//   btn_stable  debounced button level, already synchronous to clk_in
//   run_mode    asynchronous slide switch, 1 = free-run, 0 = single-step
//   halt_in     synchronous halt level from the core
//   step_en     registered one-cycle CPU advance enable
//   step_count  saturating count of step_en pulses issued
//   running     high while in RUN
//   halted      high while in HALTED

module step_controller #(
  parameter int RUN_DIV = 50000000,
  parameter int CNT_W   = 16
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             btn_stable,
  input  logic             run_mode,
  input  logic             halt_in,
  output logic             step_en,
  output logic [CNT_W-1:0] step_count,
  output logic             running,
  output logic             halted
);

  localparam int DIV_W = (RUN_DIV > 2) ? $clog2(RUN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(RUN_DIV - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    STEP     = 3'd1,
    WAIT_REL = 3'd2,
    RUN      = 3'd3,
    HALTED   = 3'd4
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_nx;
  logic             btn_prev;
  logic             run_meta;
  logic             run_s;
  logic             rise;
  logic             pulse_nx;
  logic             step_en_nx;

  assign rise = btn_stable & ~btn_prev;

  // run_mode comes straight from a switch, so it is double-flopped first.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      run_meta <= 1'b0;
      run_s    <= 1'b0;
      btn_prev <= 1'b0;
    end else begin
      run_meta <= run_mode;
      run_s    <= run_meta;
      btn_prev <= btn_stable;
    end
  end

  always_comb begin
    state_nx = state;
    div_nx   = div_q;
    pulse_nx = 1'b0;
    case (state)
      IDLE: begin
        if (halt_in) begin
          state_nx = HALTED;
        end else if (run_s) begin
          state_nx = RUN;
          div_nx   = '0;
        end else if (rise) begin
          state_nx = STEP;
        end
      end
      STEP: begin
        // The pulse is already on the output this cycle; halt only redirects.
        state_nx = halt_in ? HALTED : WAIT_REL;
      end
      WAIT_REL: begin
        if (halt_in) begin
          state_nx = HALTED;
        end else if (!btn_stable) begin
          state_nx = IDLE;
        end
      end
      RUN: begin
        if (halt_in) begin
          state_nx = HALTED;
        end else if (!run_s) begin
          state_nx = IDLE;
          div_nx   = '0;
        end else if (div_q == DIV_MAX) begin
          div_nx   = '0;
          pulse_nx = 1'b1;
        end else begin
          div_nx = div_q + 1'b1;
        end
      end
      HALTED: begin
        if (!halt_in) begin
          state_nx = IDLE;
          div_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        div_nx   = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state view so that step_en lines up
  // with the cycle the FSM actually sits in STEP.
  assign step_en_nx = pulse_nx | (state_nx == STEP);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      div_q      <= '0;
      step_en    <= 1'b0;
      running    <= 1'b0;
      halted     <= 1'b0;
      step_count <= '0;
    end else begin
      state   <= state_nx;
      div_q   <= div_nx;
      step_en <= step_en_nx;
      running <= (state_nx == RUN);
      halted  <= (state_nx == HALTED);
      if (step_en && (step_count != {CNT_W{1'b1}})) begin
        step_count <= step_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_step_controller.sv
// tb/tb_step_controller.sv - directed self-checking bench for step_controller

module tb_step_controller;

  logic        clk;
  logic        rst_n;
  logic        btn;
  logic        run;
  logic        halt;
  logic        step_en;
  logic [15:0] step_count;
  logic        running;
  logic        halted;

  logic        btn2;
  logic        run2;
  logic        halt2;
  logic        s_step_en;
  logic [2:0]  s_count;
  logic        s_running;
  logic        s_halted;

  int errors = 0;
  int checks = 0;
  int n;

  step_controller #(.RUN_DIV(4), .CNT_W(16)) u_dut (
    .clk_in     (clk),
    .rst_n      (rst_n),
    .btn_stable (btn),
    .run_mode   (run),
    .halt_in    (halt),
    .step_en    (step_en),
    .step_count (step_count),
    .running    (running),
    .halted     (halted)
  );

  step_controller #(.RUN_DIV(4), .CNT_W(3)) u_sat (
    .clk_in     (clk),
    .rst_n      (rst_n),
    .btn_stable (btn2),
    .run_mode   (run2),
    .halt_in    (halt2),
    .step_en    (s_step_en),
    .step_count (s_count),
    .running    (s_running),
    .halted     (s_halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    btn   = 1'b0;
    run   = 1'b0;
    halt  = 1'b0;
    btn2  = 1'b0;
    run2  = 1'b0;
    halt2 = 1'b0;
    cyc(2);
    chk("rst_step_en", 32'(step_en), 0);
    chk("rst_count", 32'(step_count), 0);
    chk("rst_running", 32'(running), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_sat_count", 32'(s_count), 0);
    rst_n = 1'b1;
    cyc(9);

    // Single step: one pulse per press, held button gives nothing more
    btn = 1'b1;
    chk("t1_pre", 32'(step_en), 0);
    cyc(1);
    chk("t1_pulse", 32'(step_en), 1);
    cyc(1);
    chk("t1_pulse_end", 32'(step_en), 0);
    chk("t1_count1", 32'(step_count), 1);
    n = 0;
    repeat (18) begin
      cyc(1);
      n += int'(step_en);
    end
    chk("t1_hold_pulses", 32'(n), 0);
    chk("t1_hold_count", 32'(step_count), 1);
    btn = 1'b0;
    cyc(3);
    btn = 1'b1;
    cyc(1);
    chk("t1_second_pulse", 32'(step_en), 1);
    btn = 1'b0;
    cyc(1);
    chk("t1_count2", 32'(step_count), 2);
    cyc(2);

    // Free run: entry 3 cycles after switch, pulses at +7, +11, +15
    run = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      btn = (c % 4 == 0);
      cyc(1);
      chk($sformatf("t2_step_en_c%0d", c), 32'(step_en),
          32'((c == 7) || (c == 11) || (c == 15)));
      if (c == 2) chk("t2_running_c2", 32'(running), 0);
      if (c == 3) chk("t2_running_c3", 32'(running), 1);
    end
    btn = 1'b0;
    chk("t2_count", 32'(step_count), 5);

    // Halt one cycle before the pulse due at +19
    cyc(2);
    halt = 1'b1;
    cyc(1);
    chk("t3_no_pulse", 32'(step_en), 0);
    chk("t3_halted", 32'(halted), 1);
    chk("t3_running", 32'(running), 0);
    chk("t3_count", 32'(step_count), 5);
    btn = 1'b1;
    cyc(1);
    chk("t3_press_halted_a", 32'(step_en), 0);
    btn = 1'b0;
    cyc(1);
    btn = 1'b1;
    cyc(1);
    chk("t3_press_halted_b", 32'(step_en), 0);
    btn = 1'b0;
    cyc(1);
    chk("t3_count_hold", 32'(step_count), 5);
    halt = 1'b0;
    cyc(1);
    chk("t3_idle_halted", 32'(halted), 0);
    chk("t3_idle_running", 32'(running), 0);
    cyc(1);
    chk("t3_rerun", 32'(running), 1);
    cyc(3);
    chk("t3_pre_pulse", 32'(step_en), 0);
    cyc(1);
    chk("t3_pulse", 32'(step_en), 1);
    cyc(1);
    chk("t3_count6", 32'(step_count), 6);

    // Leaving run mode exactly when the divider is at its terminal value
    run = 1'b0;
    cyc(2);
    chk("t3_still_running", 32'(running), 1);
    cyc(1);
    chk("t3_left_run", 32'(running), 0);
    chk("t3_exit_no_pulse", 32'(step_en), 0);

    // Press and halt in the same IDLE cycle
    btn  = 1'b1;
    halt = 1'b1;
    cyc(1);
    chk("t4_no_pulse", 32'(step_en), 0);
    chk("t4_halted", 32'(halted), 1);
    btn = 1'b0;
    cyc(1);
    btn = 1'b1;
    cyc(1);
    chk("t4_press_ignored", 32'(step_en), 0);
    btn  = 1'b0;
    halt = 1'b0;
    cyc(1);
    chk("t4_unhalted", 32'(halted), 0);
    cyc(1);
    chk("t4_count", 32'(step_count), 6);

    // Saturation with a 3-bit counter
    for (int k = 1; k <= 9; k++) begin
      btn2 = 1'b1;
      cyc(2);
      chk($sformatf("t5_sat_count_k%0d", k), 32'(s_count), 32'((k < 7) ? k : 7));
      btn2 = 1'b0;
      cyc(2);
    end
    chk("t5_sat_halted", 32'(s_halted), 0);
    chk("t5_sat_running", 32'(s_running), 0);
    chk("t5_sat_step_en", 32'(s_step_en), 0);
    chk("t5_main_count", 32'(step_count), 6);

    // Reset asserted while step_en is high
    btn = 1'b1;
    cyc(1);
    chk("t6_pulse", 32'(step_en), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_step_en", 32'(step_en), 0);
    chk("t6_async_count", 32'(step_count), 0);
    chk("t6_async_sat_count", 32'(s_count), 0);
    btn = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(2);
    chk("t6_post_running", 32'(running), 0);
    chk("t6_post_halted", 32'(halted), 0);
    chk("t6_post_step_en", 32'(step_en), 0);
    btn = 1'b1;
    cyc(1);
    chk("t6_idle_press", 32'(step_en), 1);
    cyc(1);
    chk("t6_count", 32'(step_count), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
